debug_trace_capture: RTL and testbench
======================================

Name: debug_trace_capture

Overview:
Parametrised on-chip trace buffer for CommsFPGA debug. It samples NUM_CH probe channels of CH_W bits each, every clock cycle, into a circular RAM. Capture stops on a programmable pattern or external trigger, keeping PRE_TRIG samples from before the trigger. Software reads the result back through a simple addressed read port. It generalises the fixed, per-signal debug taps into multi-channel, depth-configurable capture with triggering.

Parameters:
NUM_CH, 4, number of probe channels
CH_W, 9, bits per channel (covers rx_fifo_dout-style 9-bit data)
DEPTH, 256, samples stored; power of 2, >= 4
PRE_TRIG, 64, samples kept before the trigger; 0 <= PRE_TRIG < DEPTH
AW, $clog2(DEPTH), address width (derived)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
probe  in  NUM_CH*CH_W  probe bus; channel k is bits [k*CH_W +: CH_W]
arm  in  1  pulse; clear and start a capture
disarm  in  1  pulse; abort to IDLE
trig_ch  in  $clog2(NUM_CH) (min 1)  channel compared for the trigger
trig_mask  in  CH_W  compare mask
trig_value  in  CH_W  compare value
trig_edge  in  1  0 = level trigger, 1 = rising-edge-of-match trigger
trig_ext  in  1  external trigger, OR'd with the match
rd_en  in  1  read request
rd_addr  in  AW  logical sample index; 0 = oldest sample
rd_data  out  SW  sample word; SW = NUM_CH*CH_W (+16 with option)
rd_valid  out  1  rd_data is valid
state  out  3  current state encoding
done  out  1  capture complete
trig_ptr  out  AW  physical RAM address of the trigger sample

Behaviour:
- Reset values: state=IDLE, done=0, rd_valid=0, rd_data=0, trig_ptr=0. Write pointer and fill counter are both 0.
- Match: (probe[trig_ch] & trig_mask) == (trig_value & trig_mask).
- The match is registered once (match_q). Edge mode fires when match && !match_q.
- hit = (trig_edge ? edge : match) | trig_ext.
- States:
  - IDLE(0): no writes. arm moves to PRE.
  - PRE(1): writes each cycle at wptr, then wptr++ (wraps mod DEPTH) and fill++. When fill == PRE_TRIG, move to WAIT.
  - PRE with PRE_TRIG==0: arm goes directly to WAIT.
  - WAIT(2): keeps writing each cycle. On hit, the current sample is written, trig_ptr = wptr, post = 0, and the state moves to POST.
  - WAIT keeps overwriting wrapped history until a hit arrives.
  - POST(3): writes each cycle, post++. After DEPTH-PRE_TRIG-1 further samples, move to DONE. If that count is 0, go straight to DONE.
  - DONE(4): done=1 and no writes. arm starts a new capture in PRE.
- Hits are ignored in PRE, POST, DONE and IDLE.
- Priority in any state: disarm > arm > hit. arm in any state clears done, wptr, fill and post and enters PRE.
- disarm goes to IDLE and clears done. RAM contents are left undefined for software.
- Read port:
  - Legal only in DONE. Physical address = (trig_ptr - PRE_TRIG + rd_addr) mod DEPTH, computed in AW bits with natural wrap.
  - Latency is 1 cycle: rd_data and rd_valid register the cycle after rd_en. rd_valid is a 1-cycle pulse per rd_en.
  - rd_en outside DONE: rd_valid=0 and rd_data holds its previous value.
  - Back-to-back reads are allowed, one per cycle.
- Same-cycle write and read cannot occur, because reads happen only in DONE.
- reset mid-capture returns to IDLE regardless of other inputs.

Optional Feature:
Macro TRACE_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running counter is cleared on arm and increments every cycle (wraps at 0xFFFF).
  - Its value is stored in bits [SW-1 -: 16] of each sample, so SW = NUM_CH*CH_W+16.
  - The counter value at the trigger sample is also exported as trig_ts (out, 16).
- Undefined: SW = NUM_CH*CH_W, and there is no counter and no trig_ts port.

Decomposition:
- Shared package debug_trace_pkg holds:
  - the state enum (IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4);
  - the TS_W=16 constant;
  - a function computing SW from NUM_CH, CH_W and the macro.
- Sub-module trace_ram: simple dual-port RAM (DEPTH x SW) with one write port and a registered read port. It maps to LSRAM.

Test Plan:
1. NUM_CH=4, CH_W=9, DEPTH=16, PRE_TRIG=4. Channel 0 carries an incrementing count. arm, then trigger on value 0x020 with mask 0x1FF, level mode. Expect rd_addr 0..15 to return 0x01C..0x02B, rd_addr 4 = 0x020, done=1 after 11 post-trigger cycles.
2. Edge mode with the match held high across arm. Expect no trigger until the match drops and rises again. Level mode in the same setup triggers on the first cycle in WAIT.
3. trig_ext pulsed in PRE (fill < PRE_TRIG), then in WAIT. Expect the PRE pulse ignored and the WAIT pulse sets trig_ptr to the wptr of that cycle.
4. A wait longer than 3×DEPTH before the hit, so wptr wraps. Expect rd_addr 0 to be the sample exactly PRE_TRIG cycles before the trigger, with contiguous ordering across the physical wrap.
5. arm and hit in the same cycle in WAIT: capture restarts in PRE. disarm and arm together: IDLE. reset during POST: IDLE, done=0, rd_valid stays 0 for rd_en.
6. With TRACE_TIMESTAMP_EN defined: arm, then trigger at cycle 37 after arm. Expect trig_ts=37 and consecutive samples' timestamps differing by 1.

Source files
------------

// File: rtl/debug_trace_pkg.sv
// debug_trace_pkg: shared state encoding, timestamp width and sample-width helper for the trace capture (TRACE_TIMESTAMP_EN widens samples by TS_W)
package debug_trace_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;
  localparam int TS_W = 16;
  function automatic int sample_w(input int num_ch, input int ch_w);
`ifdef TRACE_TIMESTAMP_EN
    return num_ch * ch_w + TS_W;
`else
    return num_ch * ch_w;
`endif
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W simple dual-port RAM, one write port and a registered read port (i_clk, i_reset, i_we/i_waddr/i_wdata, i_re/i_raddr -> o_rdata)
module trace_ram #(
  parameter int DEPTH = 256,
  parameter int W = 36,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/debug_trace_capture.sv
// debug_trace_capture: multi-channel triggered trace buffer (probe/arm/disarm/trigger controls in, addressed read port, state/done/trig_ptr out; TRACE_TIMESTAMP_EN adds a 16-bit timestamp per sample and o_trig_ts)
module debug_trace_capture
  import debug_trace_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W = 9,
  parameter int DEPTH = 256,
  parameter int PRE_TRIG = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int TCW = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int SW = sample_w(NUM_CH, CH_W)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_CH*CH_W-1:0] i_probe,
  input  logic                 i_arm,
  input  logic                 i_disarm,
  input  logic [TCW-1:0]       i_trig_ch,
  input  logic [CH_W-1:0]      i_trig_mask,
  input  logic [CH_W-1:0]      i_trig_value,
  input  logic                 i_trig_edge,
  input  logic                 i_trig_ext,
  input  logic                 i_rd_en,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [SW-1:0]        o_rd_data,
  output logic                 o_rd_valid,
  output logic [2:0]           o_state,
  output logic                 o_done,
  output logic [AW-1:0]        o_trig_ptr
`ifdef TRACE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]      o_trig_ts
`endif
);
  localparam int NPOST = DEPTH - PRE_TRIG - 1;
  localparam logic [AW-1:0] PRE_A = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_LAST = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(NPOST - 1);
  state_t r_state;
  logic [AW-1:0] r_wptr, r_fill, r_post;
  logic r_match_q;
  logic [CH_W-1:0] w_sel;
  logic w_match, w_hit, w_we, w_re;
  logic [AW-1:0] w_raddr;
  logic [SW-1:0] w_wdata;
  assign w_sel = CH_W'(i_probe >> (i_trig_ch * CH_W));
  assign w_match = ((w_sel ^ i_trig_value) & i_trig_mask) == '0;
  assign w_hit = (i_trig_edge ? w_match & ~r_match_q : w_match) | i_trig_ext;
  assign w_we = r_state inside {S_PRE, S_WAIT, S_POST};
  assign w_re = i_rd_en && r_state == S_DONE;
  assign w_raddr = o_trig_ptr - PRE_A + i_rd_addr;
  assign o_state = r_state;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  assign w_wdata = {r_ts, i_probe};
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ts <= '0;
      o_trig_ts <= '0;
    end else begin
      r_ts <= i_arm ? '0 : r_ts + 1'b1;
      if (!i_disarm && !i_arm && r_state == S_WAIT && w_hit) o_trig_ts <= r_ts;
    end
  end
`else
  assign w_wdata = i_probe;
`endif
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      o_done <= 1'b0;
      o_rd_valid <= 1'b0;
      o_trig_ptr <= '0;
      r_wptr <= '0;
      r_fill <= '0;
      r_post <= '0;
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= w_match;
      o_rd_valid <= w_re;
      if (i_disarm) begin
        r_state <= S_IDLE;
        o_done <= 1'b0;
      end else if (i_arm) begin
        r_state <= PRE_TRIG == 0 ? S_WAIT : S_PRE;
        o_done <= 1'b0;
        r_wptr <= '0;
        r_fill <= '0;
        r_post <= '0;
      end else begin
        if (w_we) r_wptr <= r_wptr + 1'b1;
        case (r_state)
          S_PRE: begin
            r_fill <= r_fill + 1'b1;
            if (r_fill == PRE_LAST) r_state <= S_WAIT;
          end
          S_WAIT: if (w_hit) begin
            o_trig_ptr <= r_wptr;
            r_post <= '0;
            r_state <= NPOST == 0 ? S_DONE : S_POST;
            o_done <= NPOST == 0;
          end
          S_POST: begin
            r_post <= r_post + 1'b1;
            if (r_post == POST_LAST) begin
              r_state <= S_DONE;
              o_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
  trace_ram #(.DEPTH(DEPTH), .W(SW)) u_ram (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_we(w_we),
    .i_waddr(r_wptr),
    .i_wdata(w_wdata),
    .i_re(w_re),
    .i_raddr(w_raddr),
    .o_rdata(o_rd_data)
  );
endmodule

// File: tb/tb_debug_trace_capture.sv
// tb_debug_trace_capture: directed checks of capture, triggering, ordering, priorities and readback
module tb_debug_trace_capture;
  localparam int SW = debug_trace_pkg::sample_w(4, 9);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [8:0] cnt = '0;
  logic [8:0] c2 = 9'h0AA;
  logic [35:0] probe;
  logic arm = 0, disarm = 0, trig_edge = 0, trig_ext = 0, rd_en = 0;
  logic [1:0] trig_ch = '0;
  logic [8:0] trig_mask = 9'h1FF, trig_value = 9'h020;
  logic [3:0] rd_addr = '0;
  logic [SW-1:0] rd_data;
  logic rd_valid, done;
  logic [2:0] state;
  logic [3:0] trig_ptr;
  logic [8:0] tc;
  int total = 0, bad = 0;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] trig_ts;
  logic [15:0] ts4;
`endif
  assign probe = {9'(cnt + 9'd3), c2, ~cnt, cnt};
  always #5 clk = ~clk;
  debug_trace_capture #(.NUM_CH(4), .CH_W(9), .DEPTH(16), .PRE_TRIG(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_probe(probe), .i_arm(arm), .i_disarm(disarm),
    .i_trig_ch(trig_ch), .i_trig_mask(trig_mask), .i_trig_value(trig_value),
    .i_trig_edge(trig_edge), .i_trig_ext(trig_ext), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_state(state), .o_done(done),
    .o_trig_ptr(trig_ptr)
`ifdef TRACE_TIMESTAMP_EN
    , .o_trig_ts(trig_ts)
`endif
  );
  function automatic logic [35:0] ew(input logic [8:0] c, input logic [8:0] v);
    return {9'(c + 9'd3), v, ~c, c};
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cnt = cnt + 9'd1;
    end
  endtask
  task automatic do_arm();
    arm = 1;
    tick();
    arm = 0;
  endtask
  initial begin
    tick(2);
    reset = 0;
    check("rst_state", 64'(state), 0);
    check("rst_done", 64'(done), 0);
    check("rst_valid", 64'(rd_valid), 0);
    check("rst_data", 64'(rd_data), 0);
    check("rst_trig_ptr", 64'(trig_ptr), 0);
    cnt = 9'h010;
    do_arm();
    check("t1_pre", 64'(state), 1);
    tick(4);
    check("t1_wait", 64'(state), 2);
    tick(12);
    check("t1_post", 64'(state), 3);
    check("t1_trig_ptr", 64'(trig_ptr), 15);
    tick(10);
    check("t1_still_post", 64'(state), 3);
    check("t1_not_done", 64'(done), 0);
    tick();
    check("t1_done", 64'(done), 1);
    check("t1_done_state", 64'(state), 4);
    rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
      check("t1_rd_valid", 64'(rd_valid), 1);
      check($sformatf("t1_rd%0d", i), 64'(rd_data[35:0]), 64'(ew(9'(9'h01C + i), 9'h0AA)));
    end
    rd_en = 0;
    tick();
    check("t1_valid_pulse", 64'(rd_valid), 0);
    trig_ch = 2'd2;
    trig_value = 9'h0AA;
    trig_edge = 1;
    do_arm();
    tick(4);
    check("t2_wait", 64'(state), 2);
    tick(5);
    check("t2_edge_held", 64'(state), 2);
    c2 = 9'h000;
    tick();
    c2 = 9'h0AA;
    tick();
    check("t2_edge_fire", 64'(state), 3);
    check("t2_edge_ptr", 64'(trig_ptr), 10);
    disarm = 1;
    tick();
    disarm = 0;
    check("t2_disarm", 64'(state), 0);
    trig_edge = 0;
    do_arm();
    tick(4);
    check("t2_lvl_wait", 64'(state), 2);
    tick();
    check("t2_lvl_fire", 64'(state), 3);
    check("t2_lvl_ptr", 64'(trig_ptr), 4);
    trig_value = 9'h155;
    do_arm();
    tick(2);
    trig_ext = 1;
    tick();
    trig_ext = 0;
    check("t3_pre_ignore", 64'(state), 1);
    tick();
    check("t3_wait", 64'(state), 2);
    tick(3);
    trig_ext = 1;
    tick();
    trig_ext = 0;
    check("t3_ext_fire", 64'(state), 3);
    check("t3_ext_ptr", 64'(trig_ptr), 7);
    do_arm();
    tick(57);
    check("t4_long_wait", 64'(state), 2);
    c2 = 9'h155;
    tc = cnt;
    tick();
    c2 = 9'h0AA;
    tick(11);
    check("t4_done", 64'(state), 4);
    check("t4_ptr", 64'(trig_ptr), 9);
    rd_en = 1;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
      check($sformatf("t4_rd%0d", i), 64'(rd_data[35:0]),
            64'(ew(9'(tc - 9'd4 + 9'(i)), i == 4 ? 9'h155 : 9'h0AA)));
    end
    rd_en = 0;
    do_arm();
    tick(4);
    c2 = 9'h155;
    arm = 1;
    tick();
    arm = 0;
    c2 = 9'h0AA;
    check("t5_arm_over_hit", 64'(state), 1);
    arm = 1;
    disarm = 1;
    tick();
    arm = 0;
    disarm = 0;
    check("t5_disarm_over_arm", 64'(state), 0);
    do_arm();
    tick(4);
    c2 = 9'h155;
    tick();
    c2 = 9'h0AA;
    tick(2);
    check("t5_in_post", 64'(state), 3);
    reset = 1;
    arm = 1;
    tick();
    reset = 0;
    arm = 0;
    check("t5_rst_state", 64'(state), 0);
    check("t5_rst_done", 64'(done), 0);
    rd_en = 1;
    rd_addr = 4'd3;
    tick();
    rd_en = 0;
    check("t5_rd_idle_valid", 64'(rd_valid), 0);
    check("t5_rd_idle_data", 64'(rd_data), 0);
`ifdef TRACE_TIMESTAMP_EN
    do_arm();
    tick(37);
    trig_ext = 1;
    tick();
    trig_ext = 0;
    check("t6_trig_ts", 64'(trig_ts), 37);
    tick(11);
    check("t6_done", 64'(state), 4);
    rd_en = 1;
    rd_addr = 4'd4;
    tick();
    ts4 = rd_data[SW-1 -: 16];
    check("t6_ts_trig_sample", 64'(ts4), 37);
    rd_addr = 4'd5;
    tick();
    check("t6_ts_next", 64'(rd_data[SW-1 -: 16]), 64'(ts4 + 16'd1));
    rd_en = 0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
